// File: rtl/burst_gearbox_pkg.sv
// Shared types and sizing helpers for the burst gearbox (optional crop window: CROP_EN).
package burst_gearbox_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_PIXEL_BIT_WIDTH  = 10;
    localparam int DEF_PIXELS_PER_BURST = 10;
    localparam int DEF_PIXELS_PER_BEAT  = 2;
    localparam int DEF_BURST_W          = DEF_PIXEL_BIT_WIDTH * DEF_PIXELS_PER_BURST;
    localparam int DEF_BEAT_W           = DEF_PIXEL_BIT_WIDTH * DEF_PIXELS_PER_BEAT;

    function automatic int beats_per_burst(input int px_burst, input int px_beat);
        return px_burst / px_beat;
    endfunction

    function automatic int bursts_per_frame(input int rows, input int cols, input int px_burst);
        return rows * cols / px_burst;
    endfunction

    function automatic int beats_per_frame(input int rows, input int cols, input int px_beat);
        return rows * cols / px_beat;
    endfunction

    // Counter width that stays >= 1 for degenerate counts
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/burst_gearbox_if.sv
// Input burst stream and output beat stream of the burst gearbox.
interface burst_gearbox_if
    import burst_gearbox_pkg::*;
#(
    parameter int IN_W  = DEF_BURST_W,
    parameter int OUT_W = DEF_BEAT_W
);
    logic             s_axis_tvalid;
    logic             s_axis_tready;
    logic [IN_W-1:0]  s_axis_tdata;
    logic             m_axis_tvalid;
    logic             m_axis_tready;
    logic [OUT_W-1:0] m_axis_tdata;
    logic             m_axis_tuser;
    logic             m_axis_tlast;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
        output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, m_axis_tready,
        input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast
    );
endinterface

// File: rtl/burst_gearbox_slot_buffer.sv
// Two-slot (active/pending) burst store with beat-select mux.
module burst_slot_buffer
    import burst_gearbox_pkg::*;
#(
    parameter int BURST_W = DEF_BURST_W,
    parameter int BEAT_W  = DEF_BEAT_W,
    parameter int BEATS   = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [BURST_W-1:0] push_data,
    input  logic               pop,
    output logic               act_vld,
    output logic               pend_vld_nxt,
    output logic [BEAT_W-1:0]  beat_data
);
    localparam int IDX_W = cnt_w(BEATS);

    logic [BURST_W-1:0] act_q, pend_q;
    logic               pend_vld;
    logic [IDX_W-1:0]   beat_idx;
    logic               act_free;

    // Active can take new data in the same cycle its last beat leaves
    assign act_free  = !act_vld || (pop && (beat_idx == IDX_W'(BEATS - 1)));
    assign beat_data = act_q[beat_idx*BEAT_W +: BEAT_W];

    always_comb begin
        pend_vld_nxt = pend_vld;
        if (push && !act_free)
            pend_vld_nxt = 1'b1;
        else if (act_free && pend_vld)
            pend_vld_nxt = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_q    <= '0;
            pend_q   <= '0;
            act_vld  <= 1'b0;
            pend_vld <= 1'b0;
            beat_idx <= '0;
        end else begin
            pend_vld <= pend_vld_nxt;
            if (push && !act_free)
                pend_q <= push_data;
            if (act_free) begin
                beat_idx <= '0;
                if (push) begin
                    act_q   <= push_data;
                    act_vld <= 1'b1;
                end else if (pend_vld) begin
                    act_q   <= pend_q;
                    act_vld <= 1'b1;
                end else begin
                    act_vld <= 1'b0;
                end
            end else if (pop) begin
                beat_idx <= beat_idx + 1'b1;
            end
        end
    end
endmodule

// File: rtl/burst_gearbox.sv
// Wide-burst to narrow-beat gearbox with frame framing and coordinates.
// Optional crop window enabled by defining CROP_EN.
module burst_gearbox
    import burst_gearbox_pkg::*;
#(
    parameter int PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
    parameter int PIXELS_PER_BURST = DEF_PIXELS_PER_BURST,
    parameter int PIXELS_PER_BEAT  = DEF_PIXELS_PER_BEAT,
    parameter int IN_ROWS          = 20,
    parameter int IN_COLS          = 20,
    parameter int OUT_ROWS         = 10,
    parameter int OUT_COLS         = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ap_start,
    output logic                       ap_done,
    output logic                       ap_idle,
    burst_gearbox_if.slave             bus,
    output logic [$clog2(IN_COLS)-1:0] cnt_col,
    output logic [$clog2(IN_ROWS)-1:0] cnt_row
);
    localparam int BEAT_W           = PIXEL_BIT_WIDTH * PIXELS_PER_BEAT;
    localparam int BURST_W          = PIXEL_BIT_WIDTH * PIXELS_PER_BURST;
    localparam int BEATS_PER_BURST  = beats_per_burst(PIXELS_PER_BURST, PIXELS_PER_BEAT);
    localparam int BURSTS_PER_FRAME = bursts_per_frame(IN_ROWS, IN_COLS, PIXELS_PER_BURST);
    localparam int ACC_W            = cnt_w(BURSTS_PER_FRAME + 1);
    localparam int CW               = $clog2(IN_COLS);
    localparam int RW               = $clog2(IN_ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(IN_COLS - PIXELS_PER_BEAT);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_ROWS - 1);

    if ((PIXELS_PER_BURST % PIXELS_PER_BEAT) != 0 || OUT_ROWS > IN_ROWS || OUT_COLS > IN_COLS)
    begin : g_bad_cfg
        $error("burst_gearbox: illegal parameter combination");
    end

    state_t           state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic             s_ready_q, push, pop, act_vld, pend_vld_nxt, in_win, frame_last;
    logic [BEAT_W-1:0] beat_data;

`ifdef CROP_EN
    localparam logic [CW-1:0] TLAST_COL = CW'(OUT_COLS - PIXELS_PER_BEAT);
    assign in_win = (int'(cnt_row) < OUT_ROWS) && (int'(cnt_col) < OUT_COLS);
`else
    localparam logic [CW-1:0] TLAST_COL = COL_LAST;
    assign in_win = 1'b1;
`endif

    assign push                = bus.s_axis_tvalid && s_ready_q;
    assign bus.s_axis_tready   = s_ready_q;
    assign bus.m_axis_tvalid   = act_vld && in_win;
    assign bus.m_axis_tdata    = beat_data;
    assign bus.m_axis_tuser    = bus.m_axis_tvalid && (cnt_row == '0) && (cnt_col == '0);
    assign bus.m_axis_tlast    = bus.m_axis_tvalid && (cnt_col == TLAST_COL);
    // Out-of-window beats leave without a handshake, one per cycle
    assign pop        = (bus.m_axis_tvalid && bus.m_axis_tready) || (act_vld && !in_win);
    assign frame_last = pop && (cnt_row == ROW_LAST) && (cnt_col == COL_LAST);

    burst_slot_buffer #(
        .BURST_W (BURST_W),
        .BEAT_W  (BEAT_W),
        .BEATS   (BEATS_PER_BURST)
    ) u_slots (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .push_data    (bus.s_axis_tdata),
        .pop          (pop),
        .act_vld      (act_vld),
        .pend_vld_nxt (pend_vld_nxt),
        .beat_data    (beat_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ap_start) state_nxt = RUN;
            RUN:     if (frame_last) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        acc_nxt = (state == IDLE) ? '0 : acc + ACC_W'(push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            s_ready_q <= 1'b0;
            ap_done   <= 1'b0;
            ap_idle   <= 1'b1;
            cnt_col   <= '0;
            cnt_row   <= '0;
        end else begin
            state   <= state_nxt;
            acc     <= acc_nxt;
            ap_done <= (state_nxt == DONE);
            ap_idle <= (state_nxt == IDLE);
            // Registered ready, from next-cycle pending occupancy and burst quota
            s_ready_q <= (state_nxt == RUN) && !pend_vld_nxt &&
                         (acc_nxt < ACC_W'(BURSTS_PER_FRAME));
            if (frame_last) begin
                cnt_col <= '0;
                cnt_row <= '0;
            end else if (pop) begin
                if (cnt_col == COL_LAST) begin
                    cnt_col <= '0;
                    cnt_row <= cnt_row + 1'b1;
                end else begin
                    cnt_col <= cnt_col + CW'(PIXELS_PER_BEAT);
                end
            end
        end
    end
endmodule

// File: tb/tb_burst_gearbox.sv
// Directed bench for burst_gearbox: full frames, stalls, quota hold-off, abort, pass-through.
module tb_burst_gearbox;

    logic clk = 1'b0;
    logic reset, ap_start, ap_done, ap_idle;
    logic [4:0] cnt_col, cnt_row;
    logic pt_start, pt_done, pt_idle;
    logic [4:0] pt_col, pt_row;
    int checks = 0;
    int errors = 0;
    int pna, pnb;
    bit pdone;

`ifdef CROP_EN
    localparam int NEMIT = 50;
    localparam int TL_COL = 8;
    localparam int ABORT = 20;
`else
    localparam int NEMIT = 200;
    localparam int TL_COL = 18;
    localparam int ABORT = 57;
`endif

    burst_gearbox_if #(.IN_W(100), .OUT_W(20))  bi ();
    burst_gearbox_if #(.IN_W(100), .OUT_W(100)) pi ();

    burst_gearbox dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .bus(bi), .cnt_col(cnt_col), .cnt_row(cnt_row)
    );

    burst_gearbox #(.PIXELS_PER_BEAT(10)) u_pt (
        .clk(clk), .reset(reset), .ap_start(pt_start), .ap_done(pt_done), .ap_idle(pt_idle),
        .bus(pi), .cnt_col(pt_col), .cnt_row(pt_row)
    );

    always #5 clk = ~clk;

    function automatic logic [99:0] burst_word(input int b);
        logic [99:0] w;
        for (int i = 0; i < 10; i++) w[i*10 +: 10] = 10'(b*10 + i);
        return w;
    endfunction

    function automatic logic [19:0] beat_word(input int k);
        return {10'(2*k + 1), 10'(2*k)};
    endfunction

    // Input-frame beat index of the e-th emitted beat
    function automatic int exp_k(input int e);
`ifdef CROP_EN
        return (e / 5) * 10 + e % 5;
`else
        return e;
`endif
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_done"},   ap_done, 1'b0);
        check({tag, "_idle"},   ap_idle, 1'b1);
        check({tag, "_sready"}, bi.s_axis_tready, 1'b0);
        check({tag, "_mvalid"}, bi.m_axis_tvalid, 1'b0);
        check({tag, "_tuser"},  bi.m_axis_tuser, 1'b0);
        check({tag, "_tlast"},  bi.m_axis_tlast, 1'b0);
        check({tag, "_tdata"},  bi.m_axis_tdata, 20'h0);
        check({tag, "_cnt"},    {cnt_row, cnt_col}, 10'h0);
    endtask

    task automatic run_frame(input bit rnd, input int abort_at);
        int na, nb, cyc, t_acc0, t_last, k;
        bit done_seen;
        na = 0; nb = 0; cyc = 0; t_acc0 = -1; t_last = -1; done_seen = 1'b0;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        while (!done_seen && cyc < 3000) begin
            bi.s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bi.s_axis_tdata  = burst_word(na);
            bi.m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (abort_at >= 0 && nb == abort_at && bi.m_axis_tvalid) begin
                reset = 1'b1;
                @(negedge clk);
                #1;
                check_reset_outputs("abort");
                reset = 1'b0;
                return;
            end
            if (ap_done) begin
                done_seen = 1'b1;
            end else begin
                if (na >= 40) check("quota_hold", bi.s_axis_tready, 1'b0);
                if (bi.m_axis_tvalid) begin
                    k = exp_k(nb);
                    check("tdata", bi.m_axis_tdata, beat_word(k));
                    check("tuser", bi.m_axis_tuser, nb == 0);
                    check("tlast", bi.m_axis_tlast, (2*k) % 20 == TL_COL);
                    check("cnt_col", cnt_col, (2*k) % 20);
                    check("cnt_row", cnt_row, k / 10);
                    if (bi.m_axis_tready) begin
`ifndef CROP_EN
                        if (!rnd) check("beat_cycle", cyc, t_acc0 + 1 + nb);
`endif
                        nb++;
                        t_last = cyc;
                    end
                end
                if (bi.s_axis_tvalid && bi.s_axis_tready) begin
                    if (t_acc0 < 0) t_acc0 = cyc;
                    na++;
                end
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", done_seen, 1'b1);
        check("beats_out", nb, NEMIT);
        check("bursts_taken", na, 40);
`ifndef CROP_EN
        if (!rnd) check("done_cycle", cyc, t_last + 1);
`endif
        @(negedge clk);
        #1;
        check("done_pulse_end", ap_done, 1'b0);
        check("back_to_idle", ap_idle, 1'b1);
    endtask

    initial begin
        reset = 1'b1; ap_start = 1'b0; pt_start = 1'b0;
        bi.s_axis_tvalid = 1'b0; bi.s_axis_tdata = '0; bi.m_axis_tready = 1'b0;
        pi.s_axis_tvalid = 1'b0; pi.s_axis_tdata = '0; pi.m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Burst offered before ap_start must be held off
        bi.s_axis_tvalid = 1'b1;
        bi.s_axis_tdata  = '1;
        bi.m_axis_tready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("prestart_sready", bi.s_axis_tready, 1'b0);
        check("prestart_mvalid", bi.m_axis_tvalid, 1'b0);

        run_frame(1'b0, -1);
        run_frame(1'b1, -1);
        run_frame(1'b0, ABORT);

        bi.s_axis_tvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("post_abort_done", ap_done, 1'b0);
        check("post_abort_idle", ap_idle, 1'b1);
        run_frame(1'b0, -1);

`ifndef CROP_EN
        pi.s_axis_tvalid = 1'b1;
        pi.m_axis_tready = 1'b1;
        pna = 0; pnb = 0; pdone = 1'b0;
        pt_start = 1'b1;
        @(negedge clk);
        pt_start = 1'b0;
        for (int c = 0; c < 200 && !pdone; c++) begin
            pi.s_axis_tdata = burst_word(pna);
            #1;
            if (pt_done) begin
                pdone = 1'b1;
            end else begin
                if (pi.m_axis_tvalid) begin
                    check("pt_tdata", pi.m_axis_tdata, burst_word(pnb));
                    check("pt_tlast", pi.m_axis_tlast, pnb % 2 == 1);
                    pnb++;
                end
                if (pi.s_axis_tvalid && pi.s_axis_tready) pna++;
                @(negedge clk);
            end
        end
        check("pt_beats", pnb, 40);
        check("pt_done", pdone, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/burst_gearbox.md
Name: burst_gearbox

Overview:
- Parametrised successor to the single-pixel burst sequentializer.
- Accepts wide bursts of PIXELS_PER_BURST packed pixels from the CXP acquisition path and re-emits them as AXI-Stream beats of PIXELS_PER_BEAT pixels.
- Generates frame/line framing (tuser/tlast) and row/column coordinates.
- Double-buffered so back-to-back bursts stream with no bubble; sits between the CustomLogic input stream and downstream pixel processing.

Parameters:
PIXEL_BIT_WIDTH, 10, bits per pixel
PIXELS_PER_BURST, 10, pixels per input beat; multiple of PIXELS_PER_BEAT
PIXELS_PER_BEAT, 2, pixels per output beat; divides IN_COLS
IN_ROWS, 20, frame rows
IN_COLS, 20, frame columns; IN_ROWS*IN_COLS multiple of PIXELS_PER_BURST
OUT_ROWS, 10, crop window rows (CROP_EN only), <= IN_ROWS
OUT_COLS, 10, crop window columns (CROP_EN only), multiple of PIXELS_PER_BEAT, <= IN_COLS

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ap_start  in  1  start one frame
ap_done  out  1  one-cycle pulse after last beat of frame retired
ap_idle  out  1  high in IDLE
s_axis_tvalid  in  1  input burst valid
s_axis_tready  out  1  input ready
s_axis_tdata  in  PIXEL_BIT_WIDTH*PIXELS_PER_BURST  packed burst, pixel i at [i*W +: W]
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tdata  out  PIXEL_BIT_WIDTH*PIXELS_PER_BEAT  packed beat, pixel j at [j*W +: W]
m_axis_tuser  out  1  first output beat of frame
m_axis_tlast  out  1  last output beat of a line
cnt_col  out  $clog2(IN_COLS)  input-frame column of pixel 0 of current beat
cnt_row  out  $clog2(IN_ROWS)  input-frame row of current beat

Behaviour:
- Reset: state IDLE; both buffers empty; all counters 0; outputs ap_done=0, ap_idle=1, s_axis_tready=0, m_axis_tvalid=0, tuser=0, tlast=0, tdata=0, cnt_col=0, cnt_row=0. Reset mid-frame drops buffered data with no ap_done.
- FSM IDLE -> RUN on ap_start. RUN -> DONE in the cycle the final beat of the frame retires. DONE (ap_done=1, one cycle) -> IDLE. ap_start outside IDLE is ignored.
- Buffers:
  - Two burst-wide slots: active (being emitted) and pending. Each has a valid bit; beat index within active is 0..PIXELS_PER_BURST/PIXELS_PER_BEAT-1.
  - s_axis_tready = RUN && pending empty && bursts_accepted < IN_ROWS*IN_COLS/PIXELS_PER_BURST. Registered; no combinational path from m_axis_tready.
  - An accepted burst goes to active if active is empty, or if active retires its last beat in the same cycle; otherwise to pending. When active empties and pending is full, pending moves to active next cycle.
  - Steady state: one output beat per cycle under continuous tready.
- Output:
  - m_axis_tvalid = active valid (and the beat is in-window when CROP_EN is defined).
  - tdata = active[beat_idx*PIXELS_PER_BEAT*W +: PIXELS_PER_BEAT*W]. Holds stable while tvalid && !tready.
- Retire: a beat retires on handshake, or on a drop under CROP_EN. On retire, cnt_col += PIXELS_PER_BEAT. At IN_COLS-PIXELS_PER_BEAT, cnt_col wraps to 0 and cnt_row increments. At the frame end all counters return to 0.
- Framing:
  - tuser=1 only on the first emitted beat of the frame (row 0, col 0).
  - tlast=1 when cnt_col==IN_COLS-PIXELS_PER_BEAT.
- Latency: burst handshake at cycle t -> first beat valid at t+1.
- Input arriving after the frame's burst quota is held off (tready=0) until the next ap_start.

Optional Feature:
CROP_EN
- Defined: beats with cnt_row>=OUT_ROWS or cnt_col>=OUT_COLS are dropped, one per cycle, with m_axis_tvalid=0. tlast asserts at cnt_col==OUT_COLS-PIXELS_PER_BEAT. cnt_col/cnt_row still report input-frame coordinates. ap_done still waits for the full input frame.
- Undefined: no crop logic; OUT_ROWS/OUT_COLS are unused.

Decomposition:
- Package burst_gearbox_pkg holds:
  - state enum {IDLE, RUN, DONE}
  - BEATS_PER_BURST, BURSTS_PER_FRAME, BEATS_PER_FRAME constants (as functions of the parameters)
  - width localparams
- One sub-module, burst_slot_buffer: the two-slot active/pending store with valid bits and the beat-select mux. FSM, counters and framing stay in the top.

Test Plan:
- Defaults, data = pixel index, tready=1, tvalid=1: 200 beats in 200 consecutive cycles after first accept. Beat k tdata = {2k+1,2k}. tuser only on beat 0. tlast on beats 9,19,...,199. ap_done pulses once the cycle after beat 199.
- Random tready (50%) and random tvalid: pixel order intact, tdata stable during stalls, no loss or duplication, cnt_col==(2k)%20, cnt_row==2k/20.
- Input burst offered before ap_start and the 41st burst offered in-frame: tready=0 in both cases, neither burst consumed.
- Reset asserted at beat 57: next cycle all outputs at reset values. A new ap_start then restarts at pixel 0 with tuser=1 and no ap_done from the aborted frame.
- PIXELS_PER_BEAT=10, PIXELS_PER_BURST=10: pass-through, 40 beats. tlast on every 2nd beat.
- CROP_EN defined: exactly 50 beats emitted, rows 0-9 cols 0-9. tlast at col 8. ap_done only after all 200 input beats retire.
